// File: rtl/branch_predictor_bht_if.sv
// Predict/train/statistics bundle between the pipeline and the branch predictor.
// The pipeline is the master; the predictor is the slave.
interface branch_predictor_bht_if #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 64,
    parameter int STAT_W  = 32
);
    localparam int IDX_W = $clog2(ENTRIES);

    logic [XLEN-1:0]   pred_pc;
    logic              pred_taken;
    logic              pred_hit;
    logic [XLEN-1:0]   pred_target;
    logic [IDX_W-1:0]  pred_idx;

    logic              upd_valid;
    logic [XLEN-1:0]   upd_pc;
    logic [IDX_W-1:0]  upd_idx;
    logic              upd_taken;
    logic [XLEN-1:0]   upd_target;
    logic              upd_pred_taken;
    logic [XLEN-1:0]   upd_pred_target;

    logic              mispredict;
    logic [STAT_W-1:0] stat_branches;
    logic [STAT_W-1:0] stat_mispredicts;

    modport master (
        output pred_pc, upd_valid, upd_pc, upd_idx, upd_taken,
               upd_target, upd_pred_taken, upd_pred_target,
        input  pred_taken, pred_hit, pred_target, pred_idx,
               mispredict, stat_branches, stat_mispredicts
    );

    modport slave (
        input  pred_pc, upd_valid, upd_pc, upd_idx, upd_taken,
               upd_target, upd_pred_taken, upd_pred_target,
        output pred_taken, pred_hit, pred_target, pred_idx,
               mispredict, stat_branches, stat_mispredicts
    );
endinterface

// File: rtl/branch_predictor_bht.sv
// 2-bit counter BHT plus tagged BTB with saturating branch/mispredict stats.
// Optional GSHARE_EN macro folds a global history register into the counter index.
module branch_predictor_bht #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 64,
    parameter int STAT_W  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    branch_predictor_bht_if.slave  bus
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    logic [1:0]        cnt_q   [ENTRIES];
    logic [1:0]        cnt_d   [ENTRIES];
    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]  tag_q   [ENTRIES];
    logic [TAG_W-1:0]  tag_d   [ENTRIES];
    logic [XLEN-1:0]   tgt_q   [ENTRIES];
    logic [XLEN-1:0]   tgt_d   [ENTRIES];
    logic [STAT_W-1:0] br_q, br_d;
    logic [STAT_W-1:0] mp_q, mp_d;

    logic [IDX_W-1:0]  btb_idx;
    logic [IDX_W-1:0]  cnt_idx;
    logic [IDX_W-1:0]  wr_idx;
    logic              hit;
    logic              taken;
    logic              mispredict;

`ifdef GSHARE_EN
    logic [IDX_W-1:0]  ghr_q, ghr_d;

    always_comb begin
        ghr_d = ghr_q;
        if (bus.upd_valid)
            ghr_d = {ghr_q[IDX_W-2:0], bus.upd_taken};
    end

    always_ff @(posedge clk) begin
        if (rst) ghr_q <= '0;
        else     ghr_q <= ghr_d;
    end

    assign cnt_idx = bus.pred_pc[IDX_W+1:2] ^ ghr_q;
`else
    assign cnt_idx = bus.pred_pc[IDX_W+1:2];
`endif

    // Prediction reads only registered state: an update this cycle is not bypassed.
    always_comb begin
        btb_idx = bus.pred_pc[IDX_W+1:2];
        hit     = valid_q[btb_idx] &&
                  (tag_q[btb_idx] == bus.pred_pc[XLEN-1:IDX_W+2]);
        taken   = hit && cnt_q[cnt_idx][1];
    end

    assign bus.pred_hit    = hit;
    assign bus.pred_taken  = taken;
    assign bus.pred_idx    = cnt_idx;
    assign bus.pred_target = taken ? tgt_q[btb_idx]
                                   : bus.pred_pc + XLEN'(4);

    assign mispredict = bus.upd_valid &&
        ((bus.upd_taken != bus.upd_pred_taken) ||
         (bus.upd_taken && (bus.upd_target != bus.upd_pred_target)));
    assign bus.mispredict = mispredict;

    always_comb begin
        cnt_d   = cnt_q;
        valid_d = valid_q;
        tag_d   = tag_q;
        tgt_d   = tgt_q;
        wr_idx  = bus.upd_pc[IDX_W+1:2];
        if (bus.upd_valid) begin
            if (bus.upd_taken) begin
                if (cnt_q[bus.upd_idx] != 2'b11)
                    cnt_d[bus.upd_idx] = cnt_q[bus.upd_idx] + 2'b01;
                valid_d[wr_idx] = 1'b1;
                tag_d[wr_idx]   = bus.upd_pc[XLEN-1:IDX_W+2];
                tgt_d[wr_idx]   = bus.upd_target;
            end else if (cnt_q[bus.upd_idx] != 2'b00) begin
                cnt_d[bus.upd_idx] = cnt_q[bus.upd_idx] - 2'b01;
            end
        end
    end

    always_comb begin
        br_d = br_q;
        mp_d = mp_q;
        if (bus.upd_valid && (br_q != '1))
            br_d = br_q + STAT_W'(1);
        if (mispredict && (mp_q != '1))
            mp_d = mp_q + STAT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++)
                cnt_q[i] <= 2'b01;
            valid_q <= '0;
            br_q    <= '0;
            mp_q    <= '0;
        end else begin
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            br_q    <= br_d;
            mp_q    <= mp_d;
        end
    end

    // Tags and targets are qualified by valid bits, so they need no reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tag_q <= tag_d;
            tgt_q <= tgt_d;
        end
    end

    assign bus.stat_branches    = br_q;
    assign bus.stat_mispredicts = mp_q;
endmodule

// File: doc/branch_predictor_bht.md
# branch_predictor_bht

Parametrised dynamic branch predictor that replaces the static equal-compare predictor in the 5-stage pipeline. It sits beside the program counter and IF/ID register. Each cycle it gives a fetch-stage prediction from a table of 2-bit saturating counters plus a tagged branch target buffer (BTB). It is trained by branch resolution from the ID/EX side, and it keeps saturating branch and mispredict statistics.

## Interface
Parameters:
- XLEN, 32, address/data width.
- ENTRIES, 64, counter-table and BTB depth; power of two, at least 4.
- IDX_W, $clog2(ENTRIES), index width; derived, not overridden.
- STAT_W, 32, statistics counter width.

Ports:
- clk  in  1  rising-edge clock; the design's only clock.
- rst  in  1  reset; synchronous and active-high.
- pred_pc  in  XLEN  fetch PC.
- pred_taken  out  1  predicted taken.
- pred_hit  out  1  BTB hit for pred_pc.
- pred_target  out  XLEN  predicted next PC.
- pred_idx  out  IDX_W  counter index used; the pipeline carries it to the update.
- upd_valid  in  1  resolved conditional branch this cycle.
- upd_pc  in  XLEN  PC of the resolved branch.
- upd_idx  in  IDX_W  pred_idx captured at fetch.
- upd_taken  in  1  actual outcome.
- upd_target  in  XLEN  actual taken target.
- upd_pred_taken  in  1  prediction made at fetch.
- upd_pred_target  in  XLEN  target predicted at fetch.
- mispredict  out  1  combinational flag; the flush request.
- stat_branches  out  STAT_W  resolved-branch count.
- stat_mispredicts  out  STAT_W  mispredict count.

## Operation
- BTB index = pc[IDX_W+1:2]; tag = pc[XLEN-1:IDX_W+2]. Each BTB entry holds a valid bit, a tag and a target.
- Counter index pred_idx = pred_pc[IDX_W+1:2]. With GSHARE_EN, pred_idx is that value XOR the global history register (GHR).
- pred_hit = valid[btb_idx] && tag match.
- pred_taken = pred_hit && cnt[pred_idx][1].
- pred_target = pred_taken ? btb_target : pred_pc + 4, computed modulo 2^XLEN.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Training when upd_valid=1:
  - cnt[upd_idx] increments if upd_taken, otherwise decrements; it saturates at 11 and 00.
  - If upd_taken, the BTB entry at upd_pc is written: valid=1, tag, and upd_target. A not-taken outcome never modifies the BTB.
  - GHR shifts left with upd_taken in the LSB (GSHARE_EN only).
- mispredict = upd_valid && ((upd_taken != upd_pred_taken) || (upd_taken && upd_target != upd_pred_target)).
- Statistics: stat_branches increments on upd_valid; stat_mispredicts increments on mispredict. Both saturate at all-ones and never wrap.
- Aliasing: PCs with equal index but different tag give pred_hit=0 and therefore a not-taken prediction. The shared counter is still trained by both branches.

## Timing
- Prediction is combinational from registered state, with zero-cycle latency.
- Update is written on the rising edge of clk and is visible to predictions starting the next cycle.
- Simultaneous predict and update on the same index: the prediction returns the pre-update (old) value. There is no bypass.
- Updates arrive one per cycle; back-to-back updates to the same index accumulate, each applied to the previous cycle's result.
- Reset values, all applied in one rst cycle:
  - every counter 01;
  - every BTB valid bit 0 (tags and targets don't-care);
  - GHR 0;
  - stat_branches and stat_mispredicts 0.
  - Outputs immediately after reset: pred_hit=0, pred_taken=0, pred_target=pred_pc+4.
- rst asserted in the same cycle as upd_valid: reset wins and the update is discarded.
- mispredict is combinational from the upd_* inputs and is independent of rst.

## Configuration
- GSHARE_EN defined:
  - an IDX_W-bit GHR is instantiated;
  - pred_idx = pred_pc[IDX_W+1:2] ^ GHR;
  - the GHR shifts on every upd_valid.
- GSHARE_EN undefined:
  - no GHR;
  - pred_idx = pred_pc[IDX_W+1:2] (bimodal);
  - all ports remain present.

## Test plan
Benches use ENTRIES=16 unless noted.
- Reset, then pred_pc=0x40 -> pred_hit=0, pred_taken=0, pred_target=0x44, pred_idx=0, both stats 0.
- One update: pc=0x40, taken, target 0x100, pred_taken=0, pred_target=0x44 -> mispredict=1 that cycle. Next cycle pred_pc=0x40 gives pred_hit=1, pred_taken=1, pred_target=0x100, stat_branches=1, stat_mispredicts=1.
- Saturation:
  - 4 taken updates at 0x40, then 1 not-taken -> still taken (counter 10).
  - 3 further not-taken -> counter 00, pred_taken=0, pred_hit=1.
- Alias: train 0x40 taken to 0x100, then pred_pc=0x80 (same index 0) -> pred_hit=0, pred_target=0x84.
- Update and predict of pc 0x40 in the same cycle from reset -> that cycle shows pred_taken=0 and the following cycle shows 1. rst asserted together with upd_valid -> counter stays 01 and stats stay 0.
- Statistics saturation: STAT_W=4, 20 mispredicting updates -> stat_mispredicts=15 and stat_branches=15, with no wrap.
- Index hashing: with GSHARE_EN, after taken updates at pcs 0x40 then 0x44 (GHR=0011), pred_pc=0x40 gives pred_idx=3. Without GSHARE_EN the same sequence gives pred_idx=0.
